// File: rtl/bip_pkg.sv
// Shared BIP definitions: opcode map, fetch FSM state encoding, instruction field slicing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Macro BIP_FETCH_STEP_EN adds the STEP_WAIT state to the FSM encoding.
package bip_pkg;

  // Opcode field is the top OPC_W bits of every instruction.
  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_HLT  = 5'd0;
  localparam logic [OPC_W-1:0] OP_STO  = 5'd1;
  localparam logic [OPC_W-1:0] OP_LD   = 5'd2;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'd3;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'd4;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'd5;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd6;
  localparam logic [OPC_W-1:0] OP_SUBI = 5'd7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LOAD      = 3'd2,
    ST_EXEC      = 3'd3,
`ifdef BIP_FETCH_STEP_EN
    ST_HALT      = 3'd4,
    ST_STEP_WAIT = 3'd5
`else
    ST_HALT      = 3'd4
`endif
  } state_t;

  // Field slicing for an instruction of width instr_w:
  // opcode = [instr_w-1 -: OPC_W], operand = [opnd_msb(instr_w):0].
  function automatic int opc_msb(input int instr_w);
    return instr_w - 1;
  endfunction

  function automatic int opnd_msb(input int instr_w);
    return instr_w - OPC_W - 1;
  endfunction

endpackage

// File: rtl/bip_pc_reg.sv
// Program counter: clears on reset or clr, increments modulo 2^PC_W on inc, otherwise holds.
// Latency: 1 clock from clr/inc to pc.
// Backpressure: none; clr has priority over inc.
// Ports: clk, rst (sync active-high), clr, inc, pc[PC_W-1:0].
module bip_pc_reg #(
  parameter int PC_W = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] r_pc;

  // All-ones wraps to zero naturally through the PC_W-bit add.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_pc <= '0;
    end else if (inc) begin
      r_pc <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
    end
  end

  assign pc = r_pc;

endmodule

// File: rtl/bip_fetch_control.sv
// BIP fetch/sequence stage: PC, synchronous program read, instruction register, start-to-halt cycle counter.
// Latency: 3 clocks per instruction (FETCH, LOAD, EXEC); first exec_valid 3 clocks after start is sampled.
// Backpressure: none; WrPC=0 in EXEC halts until rst. Macro BIP_FETCH_STEP_EN adds step input + STEP_WAIT.
// Ports: clk, rst, start | prog_addr, prog_rd, prog_data | WrPC, opcode, operand, exec_valid |
//        pc, halted, cycle_cnt | step (BIP_FETCH_STEP_EN only).
module bip_fetch_control
  import bip_pkg::*;
#(
  parameter int PC_W    = 11,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [PC_W-1:0]          prog_addr,
  output logic                     prog_rd,
  input  logic [INSTR_W-1:0]       prog_data,
  input  logic                     WrPC,
  output logic [OPC_W-1:0]         opcode,
  output logic [INSTR_W-OPC_W-1:0] operand,
  output logic                     exec_valid,
  output logic [PC_W-1:0]          pc,
  output logic                     halted,
`ifdef BIP_FETCH_STEP_EN
  output logic [CNT_W-1:0]         cycle_cnt,
  input  logic                     step
`else
  output logic [CNT_W-1:0]         cycle_cnt
`endif
);

  state_t             r_state;
  state_t             w_next_state;
  logic [INSTR_W-1:0] r_ir;
  logic [CNT_W-1:0]   r_cnt;
  logic [PC_W-1:0]    w_pc;

  logic w_prog_rd;
  logic w_exec_valid;
  logic w_halted;
  logic w_pc_clr;
  logic w_pc_inc;
  logic w_ir_ld;
  logic w_cnt_clr;
  logic w_cnt_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_prog_rd    = 1'b0;
    w_exec_valid = 1'b0;
    w_halted     = 1'b0;
    w_pc_clr     = 1'b0;
    w_pc_inc     = 1'b0;
    w_ir_ld      = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pc_clr = 1'b1;
        if (start) begin
          w_cnt_clr    = 1'b1;
          w_next_state = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_prog_rd    = 1'b1;
        w_cnt_en     = 1'b1;
        w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        // prog_data is the word addressed during FETCH.
        w_ir_ld      = 1'b1;
        w_cnt_en     = 1'b1;
        w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        w_exec_valid = 1'b1;
        w_cnt_en     = 1'b1;
        if (WrPC) begin
          w_pc_inc     = 1'b1;
`ifdef BIP_FETCH_STEP_EN
          w_next_state = ST_STEP_WAIT;
`else
          w_next_state = ST_FETCH;
`endif
        end else begin
          w_next_state = ST_HALT;
        end
      end
      ST_HALT: begin
        w_halted = 1'b1;
      end
`ifdef BIP_FETCH_STEP_EN
      ST_STEP_WAIT: begin
        w_cnt_en = 1'b1;
        if (step) begin
          w_next_state = ST_FETCH;
        end
      end
`endif
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  bip_pc_reg #(
    .PC_W (PC_W)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .clr (w_pc_clr),
    .inc (w_pc_inc),
    .pc  (w_pc)
  );

  // IR only changes on the LOAD->EXEC edge, so opcode/operand are stable in every other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir <= '0;
    end else if (w_ir_ld) begin
      r_ir <= prog_data;
    end
  end

  // Cleared when leaving IDLE, counts active states, saturates at all-ones, frozen otherwise.
  always_ff @(posedge clk) begin
    if (rst || w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_en && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign prog_addr  = w_pc;
  assign pc         = w_pc;
  assign prog_rd    = w_prog_rd;
  assign exec_valid = w_exec_valid;
  assign halted     = w_halted;
  assign cycle_cnt  = r_cnt;
  assign opcode     = r_ir[opc_msb(INSTR_W) -: OPC_W];
  assign operand    = r_ir[opnd_msb(INSTR_W):0];

endmodule

// File: tb/tb_bip_fetch_control.sv
// Scoreboard bench for bip_fetch_control: random programs against a program-level reference model.
// Latency: expected fetch/exec cycles derived from 3 clocks per instruction.
// Backpressure: bench plays the decoder (WrPC) and the synchronous program memory.
module tb_bip_fetch_control;

  localparam int PC_W    = 3;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 8;
  localparam int DEPTH   = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    int cyc;
    int pc;
    int op;
    int opnd;
    int cnt;
  } exp_t;

  typedef struct {
    int pc;
    int cnt;
  } hexp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [PC_W-1:0]      prog_addr;
  logic                 prog_rd;
  logic [INSTR_W-1:0]   prog_data = '0;
  logic                 wrpc;
  logic [4:0]           opcode;
  logic [INSTR_W-6:0]   operand;
  logic                 exec_valid;
  logic [PC_W-1:0]      pc;
  logic                 halted;
  logic [CNT_W-1:0]     cycle_cnt;
`ifdef BIP_FETCH_STEP_EN
  logic                 step = 1'b0;
  bit                   step_mode = 1'b0;
`endif

  logic [INSTR_W-1:0]   mem [DEPTH];
  exp_t                 sbq [$];
  hexp_t                hq  [$];
  int                   cyc = 0;
  int                   n_exec = 0;
  int                   limit = 1000;
  int                   n_chk = 0;
  int                   n_err = 0;
  logic                 rst_q = 1'b1;
  logic                 halted_d = 1'b0;
  int                   cur_ir = 0;
  bit                   waiting = 1'b0;

  always #5 clk = ~clk;

  bip_fetch_control #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .prog_addr  (prog_addr),
    .prog_rd    (prog_rd),
    .prog_data  (prog_data),
    .WrPC       (wrpc),
    .opcode     (opcode),
    .operand    (operand),
    .exec_valid (exec_valid),
    .pc         (pc),
    .halted     (halted),
`ifdef BIP_FETCH_STEP_EN
    .cycle_cnt  (cycle_cnt),
    .step       (step)
`else
    .cycle_cnt  (cycle_cnt)
`endif
  );

  // Synchronous program memory: data one clock after prog_rd.
  always @(posedge clk) begin
    if (prog_rd) prog_data <= mem[prog_addr];
  end

  // Decoder stand-in: advance on any non-HLT opcode until the run's instruction limit.
  assign wrpc = (opcode != 5'd0) && (n_exec + 1 < limit);

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
    if (rst) n_exec <= 0;
    else if (exec_valid) n_exec <= n_exec + 1;
  end

`ifdef BIP_FETCH_STEP_EN
  always @(posedge clk) step <= step_mode && (cyc % 10 == 9);
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // Reference model: walk the program from address 0, one entry per executed instruction.
  task automatic predict(input int p0, input int lim, input bit stepm);
    int    p = 0;
    exp_t  e;
    hexp_t h;
    logic [INSTR_W-1:0] w;
    for (int k = 0; k < lim; k++) begin
      w      = mem[p];
      e.pc   = p;
      e.op   = int'(w[15:11]);
      e.opnd = int'(w[10:0]);
      e.cyc  = stepm ? -1 : p0 + 3 + 3 * k;
      e.cnt  = stepm ? -1 : sat(3 * k + 2);
      sbq.push_back(e);
      if (e.op != 0 && k + 1 < lim) begin
        p = (p + 1) % DEPTH;
      end else begin
        h.pc  = p;
        h.cnt = stepm ? -1 : sat(3 * (k + 1));
        hq.push_back(h);
        break;
      end
    end
  endtask

  // Monitor: pops the scoreboard on exec_valid and halt, checks fetches and IR stability every cycle.
  always @(negedge clk) begin
    exp_t  e;
    hexp_t h;
    if (cyc >= 2) begin
      if (rst_q) cur_ir = 0;
      chk("addr_eq_pc", int'(prog_addr), int'(pc));
      chk("fetch_expected", int'(prog_rd && sbq.size() == 0), 0);
      if (prog_rd && sbq.size() > 0) begin
        chk("fetch_addr", int'(prog_addr), sbq[0].pc);
        if (sbq[0].cyc >= 0) chk("fetch_cycle", cyc, sbq[0].cyc - 2);
      end
      chk("step_wait_fetch", int'(prog_rd && waiting), 0);
`ifdef BIP_FETCH_STEP_EN
      if (step) waiting = 1'b0;
`endif
      chk("exec_expected", int'(exec_valid && sbq.size() == 0), 0);
      if (exec_valid && sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("exec_pc", int'(pc), e.pc);
        chk("exec_opcode", int'(opcode), e.op);
        chk("exec_operand", int'(operand), e.opnd);
        if (e.cyc >= 0) chk("exec_cycle", cyc, e.cyc);
        if (e.cnt >= 0) chk("exec_cycle_cnt", int'(cycle_cnt), e.cnt);
        cur_ir = (e.op << 11) | e.opnd;
`ifdef BIP_FETCH_STEP_EN
        waiting = wrpc;
`endif
      end else if (!exec_valid) begin
        chk("ir_hold", int'({opcode, operand}), cur_ir);
      end
      if (halted && !halted_d) begin
        chk("halt_expected", int'(hq.size() == 0), 0);
        if (hq.size() > 0) begin
          h = hq.pop_front();
          chk("halt_pc", int'(pc), h.pc);
          if (h.cnt >= 0) chk("halt_cycle_cnt", int'(cycle_cnt), h.cnt);
        end
      end
      halted_d = halted;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    sbq.delete();
    hq.delete();
    waiting = 1'b0;
  endtask

  task automatic pulse_start(output int p0);
    @(posedge clk); #1 start = 1'b1;
    p0 = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    chk("halt_reached", int'(halted), 1);
    repeat (2) @(negedge clk);
    chk("sb_drained", sbq.size() + hq.size(), 0);
    sbq.delete();
    hq.delete();
  endtask

  task automatic run(input int lim, input bit stepm);
    int p0;
    limit = lim;
    @(posedge clk); #1 start = 1'b1;
    p0 = cyc;
    predict(p0, lim, stepm);
    @(posedge clk); #1 start = 1'b0;
    wait_halt(5000);
  endtask

  task automatic load_straight();
    mem[0] = 16'h1801;
    mem[1] = 16'h2802;
    mem[2] = 16'h0800;
    mem[3] = 16'h0000;
    for (int i = 4; i < DEPTH; i++) mem[i] = 16'h1801;
  endtask

  task automatic load_random(input int lo_op);
    for (int i = 0; i < DEPTH; i++)
      mem[i] = {5'($urandom_range(7, lo_op)), 11'($urandom)};
  endtask

  initial begin
    int p0;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset.
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("idle_pc", int'(pc), 0);
    chk("idle_prog_rd", int'(prog_rd), 0);
    chk("idle_cycle_cnt", int'(cycle_cnt), 0);
    chk("idle_halted", int'(halted), 0);
    chk("idle_exec_valid", int'(exec_valid), 0);
    chk("idle_opcode", int'(opcode), 0);
    chk("idle_operand", int'(operand), 0);

    // Straight-line program, then halt stickiness.
    load_straight();
    run(1000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pulse_start(p0);
      repeat (2) @(posedge clk);
    end
    @(negedge clk);
    chk("sticky_halted", int'(halted), 1);
    chk("sticky_pc", int'(pc), 3);
    chk("sticky_cycle_cnt", int'(cycle_cnt), 12);

    // Reset during LOAD of the second instruction.
    do_reset();
    load_straight();
    limit = 1000;
    pulse_start(p0);
    predict(p0, 1000, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_pc", int'(pc), 0);
    chk("rst_mid_exec_valid", int'(exec_valid), 0);
    chk("rst_mid_opcode", int'(opcode), 0);
    chk("rst_mid_prog_rd", int'(prog_rd), 0);
    chk("rst_mid_cycle_cnt", int'(cycle_cnt), 0);
    chk("rst_mid_pending", sbq.size(), 3);
    sbq.delete();
    hq.delete();
    repeat (6) @(negedge clk);
    chk("rst_mid_idle_pc", int'(pc), 0);

    // PC wrap: 12 non-HLT instructions pass 7 -> 0 and stop at pc 3.
    do_reset();
    load_random(1);
    run(12, 1'b0);

    // Cycle counter saturation: 90 instructions exceed the counter range.
    do_reset();
    load_random(1);
    run(90, 1'b0);

    // Random programs with random HLT placement and instruction limits.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      load_random(0);
      run(int'($urandom_range(30, 1)), 1'b0);
    end

`ifdef BIP_FETCH_STEP_EN
    do_reset();
    load_straight();
    step_mode = 1'b1;
    run(1000, 1'b1);
    step_mode = 1'b0;
    chk("step_halt_pc", int'(pc), 3);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bip_fetch_control.md
# bip_fetch_control

Fetch and sequencing stage of the BIP processor. It holds the program counter, reads 16-bit instructions from the synchronous program memory, and presents `opcode` to the instruction decoder and `operand` to the datapath. It consumes the decoder's `WrPC` to either advance or halt. It also counts clock cycles from start to halt.

## Interface
- `PC_W`, 11: program counter / program memory address width.
- `INSTR_W`, 16: instruction width; opcode = [INSTR_W-1 -: 5], operand = [INSTR_W-6:0].
- `CNT_W`, 16: cycle counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; leaves IDLE.
- `prog_addr`  out  PC_W  program memory address.
- `prog_rd`  out  1  program memory read enable.
- `prog_data`  in  INSTR_W  program memory read data, valid 1 cycle after `prog_rd`.
- `WrPC`  in  1  from the instruction decoder; 1 = advance, 0 = halt.
- `opcode`  out  5  instruction register opcode field, to the decoder.
- `operand`  out  INSTR_W-5  instruction register operand field, to the datapath.
- `exec_valid`  out  1  high exactly during the EXEC cycle; the datapath commits only when it is high.
- `pc`  out  PC_W  current program counter.
- `halted`  out  1  high in HALT.
- `cycle_cnt`  out  CNT_W  clocks elapsed since start.
- `step`  in  1  present only with `BIP_FETCH_STEP_EN`.

## Operation
- States: IDLE, FETCH, LOAD, EXEC, HALT, plus STEP_WAIT when `BIP_FETCH_STEP_EN` is defined.
- **IDLE**: `pc`=0. On `start`=1, go to FETCH.
- **FETCH**: `prog_rd`=1, `prog_addr`=`pc`. Go to LOAD.
- **LOAD**: IR <= `prog_data`. Go to EXEC.
- **EXEC**: `exec_valid`=1; `opcode`/`operand` come from IR.
  - If `WrPC`=1: `pc` <= `pc`+1, modulo 2^PC_W; 2^PC_W−1 wraps to 0 with no flag. Go to FETCH, or to STEP_WAIT in step mode.
  - If `WrPC`=0: `pc` is unchanged. Go to HALT.
- **HALT**: `halted`=1. Remains until `rst`; `start` is ignored.
- `start` is ignored in every state except IDLE.
- `opcode`/`operand` hold the IR value in every state. They change only on the LOAD→EXEC edge.
- `prog_addr` = `pc` at all times. `prog_rd` is high only in FETCH.
- `cycle_cnt`:
  - Cleared on the IDLE→FETCH transition.
  - Increments every clock in FETCH, LOAD, EXEC and STEP_WAIT.
  - Frozen in HALT and IDLE.
  - Saturates at 2^CNT_W−1.

## Timing
- Reset values: state IDLE, `pc`=0, IR=0 (`opcode`=0, `operand`=0), `prog_rd`=0, `exec_valid`=0, `halted`=0, `cycle_cnt`=0.
- `rst` at any point, including mid-fetch or in HALT, forces reset values on the next edge. It has priority over `start` and `step`.
- Instruction latency is 3 clocks (FETCH, LOAD, EXEC). Throughput is 1 instruction per 3 clocks.
- `start` sampled at edge N gives FETCH in cycle N+1, `prog_rd` high in N+1, and the first `exec_valid` in N+3.
- `WrPC` is sampled only in EXEC; its value elsewhere is don't-care.
- The decoder is combinational, so `WrPC` must settle within the EXEC cycle.

## Configuration
- `BIP_FETCH_STEP_EN` defined:
  - Adds the `step` input and the STEP_WAIT state.
  - EXEC with `WrPC`=1 goes to STEP_WAIT, which holds until `step`=1 and then goes to FETCH.
  - `step` is ignored in all other states.
  - `cycle_cnt` still counts in STEP_WAIT.
- Undefined: no `step` port, no STEP_WAIT state; EXEC goes directly to FETCH.

## Structure
- Shared package `bip_pkg` holds:
  - the opcode width (5) and the opcode localparams (HALT=0 … SUBI=7);
  - the state enum encoding;
  - the field-slice constants for opcode and operand.
- One natural sub-module, `bip_pc_reg`: the PC register with increment/wrap, load-zero on reset and IDLE, and hold.
- Everything else lives in the top FSM.

## Test plan
- Reset then idle: hold `start`=0 for 10 clocks → `pc`=0, `prog_rd`=0, `cycle_cnt`=0, `halted`=0.
- Straight-line program: memory {0x1801 (LDI 1), 0x2802 (ADDI 2), 0x0800 (STO 0), 0x0000 (HLT)}, pulse `start` → `exec_valid` pulses on every 3rd cycle with `opcode`s 3, 5, 1, 0; `halted`=1 with `pc`=3; `cycle_cnt`=12.
- Halt stickiness: after halt, pulse `start` 3 times → state stays HALT, `pc`=3, `cycle_cnt` frozen at 12.
- PC wrap: PC_W=3, locations 0–7 hold LDI and location 0 is reached again → `pc` goes 7→0 and fetching continues; `prog_addr` = 0.
- Reset mid-operation: assert `rst` in the LOAD cycle of the 2nd instruction → next cycle `pc`=0, `exec_valid`=0, `opcode`=0, state IDLE.
- Step mode (`BIP_FETCH_STEP_EN`): same program as the straight-line test, `step` pulsed every 10 clocks → exactly one `exec_valid` per `step` pulse; `prog_rd` stays low while waiting.
